// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default datapath width and the
// state encoding of the multiply sequencer.
package alu_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    // True when the decoded ALU control code selects the multiplier.
    function automatic logic is_mul(input logic [2:0] code);
        return code == ALU_MUL;
    endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Shift-add multiply datapath: accumulator, shifting multiplicand and
// multiplier. One partial product is added per step; the low DATA_W bits of
// the product build up in acc.
module mul_shift_add_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic [DATA_W-1:0] acc,
    output logic              mplier_zero
);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;

    // Capture operands on load, otherwise run one shift-add iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset as well, so acc reads 0 (not X) after reset.
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments: every register below sees pre-edge values.
            acc    <= '0;
            mcand  <= multiplicand;
            mplier <= multiplier;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Multiplier becomes zero after the current step: no partial products remain.
    assign mplier_zero = (mplier[DATA_W-1:1] == '0);

endmodule

// File: rtl/mul_ex_sequencer.sv
// EX-stage multiply sequencer. Detects a live mul, freezes the front of the
// pipeline while the shift-add core iterates, then presents the product for
// exactly one cycle with the stall released so writeback picks it up.
module mul_ex_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        ALUCtrl_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o
);

    localparam int              CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    mul_state_e        state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] acc;
    logic              mplier_zero;
    logic              start;
    logic              load;
    logic              step;
    logic              last_iter;

    assign start     = valid_i && is_mul(ALUCtrl_i) && !flush_i;
    assign load      = (state == ST_IDLE) && start;
    assign step      = (state == ST_BUSY) && !flush_i;
    assign last_iter = (count == LAST_ITER) || (EARLY_EXIT && mplier_zero);

    mul_shift_add_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .load         (load),
        .step         (step),
        .multiplicand (data1_i),
        .multiplier   (data2_i),
        .acc          (acc),
        .mplier_zero  (mplier_zero)
    );

    // Sequencer: idle -> busy iterations -> one-cycle done; keeps the last product.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            count    <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_BUSY;
                        count <= '0;
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                        if (last_iter) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Inputs are ignored here: the same mul is still on them.
                    if (!flush_i) begin
                        result_q <= acc;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pipeline handshake: stall while multiplying, pulse valid in the done cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        if (rst_i) begin
            unique case (state)
                ST_IDLE: stall_o        = start;
                ST_BUSY: stall_o        = !flush_i;
                ST_DONE: result_valid_o = !flush_i;
                default: stall_o        = 1'b0;
            endcase
        end
    end

    assign busy_o   = (state != ST_IDLE);
    assign result_o = (state == ST_DONE) ? acc : result_q;

endmodule
